memory_bank_unit: RTL and testbench
===================================

// Module: memory_bank_unit
// PURPOSE
//  Memory Bank Unit: eight 8-bit bank registers MB0..MB7 that extend the 16-bit address to 24 bits via aext.
//  Includes the 4-phase processor-cycle sequencer (clock generator) so the block runs from one system clock.
//  Sits between the control unit (waddr/raddr microcode fields, IR) and the address bus.
// PARAMETERS
//  ROM_BANK   8'h80  power-on value of every MBn when booting from ROM
//  RAM_BANK   8'h00  power-on value of every MBn when booting from RAM
// PORTS
//  clk         in   1  system clock; all state changes on rising edge
//  rsthold     in   1  reset; synchronous and active-high
//  waddr       in   5  microcode write-unit address
//  raddr       in   5  microcode read-unit address
//  ir          in   3  IR[2:0], bank register index for MB transfers and indexed addressing
//  nir_idx     in   1  active-low; current instruction uses indexed (IDX) addressing
//  ibus_in     in   8  internal bus low byte (write data)
//  ibus_out    out  8  read data for internal bus low byte
//  ibus_oe     out  1  high while ibus_out must drive the bus
//  nfpram_rom  in   1  boot source: 0 = RAM, 1 = ROM
//  aext        out  8  address extension (A23..A16)
//  nwar        out  1  active-low decoded "write AR" strobe for the flag unit
//  phase       out  2  processor-cycle phase 0..3 (clk1..clk4)
//  t34         out  1  high during phases 2 and 3
// BEHAVIOUR
//  Sequencer: phase counts 0,1,2,3,0... every clk; rsthold forces phase=0. t34 = phase[1].
//  Codes: raddr 5'b11011 = READ_MBN; waddr 5'b11011 = WRITE_MBN, 5'b11100 = WRITE_CTX, 5'b00010 = WAR.
//  READ_MBN: ibus_oe=1 and ibus_out = effective MB[ir] combinationally, for as long as raddr holds the code.
//  WRITE_MBN: MB[ir] <= ibus_in on the clk edge where phase==3; visible on aext/ibus_out next cycle.
//  WRITE_CTX: ctx <= ibus_in[0] on the phase==3 edge.
//  nwar = 0 only while waddr==WAR and t34==1; otherwise 1.
//  aext select: nir_idx==0 -> MB[ir]; else MB[{2'b00,ctx}] (ctx 0 = MB0 code, 1 = MB1 data).
//  Power-on mode: set by rsthold. While set, every MBn reads (ibus_out, aext) as ROM_BANK if nfpram_rom=1,
//   else RAM_BANK, evaluated live from nfpram_rom. Storage contents are ignored (undefined, SRAM-like).
//  Power-on mode clears on the first WRITE_MBN commit; that write's value lands in MB[ir];
//   the other seven registers then expose their raw (possibly undefined) storage.
//  Reset values: phase=0, t34=0, ctx=0, power-on mode=1, nwar=1, ibus_oe=0.
//   MB storage is NOT reset.
//  Reset mid-cycle: pending write discarded (reset wins over a phase-3 commit on the same edge).
//  Unknown waddr/raddr codes: no effect, ibus_oe=0. Simultaneous READ_MBN and WRITE_MBN on the same index:
//   ibus_out shows the old value until the commit edge.
// CONFIGURATION
//  MBU_IDX_EN defined: indexed selection via nir_idx as above.
//  MBU_IDX_EN undefined: nir_idx ignored; aext always MB[{2'b00,ctx}]. READ_MBN/WRITE_MBN still use ir.
// TESTING
//  Reset 5 cycles, release; phase sequence 0,1,2,3,0 and t34 = 0,0,1,1 -> checked each clk.
//  Power-on, nfpram_rom=0, ir=0..7, raddr=READ_MBN -> ibus_out=8'h00, ibus_oe=1.
//   Repeat with nfpram_rom=1 -> 8'h80; aext matches.
//  WRITE_MBN ir=3 ibus_in=8'h5A, then READ_MBN ir=3 -> 8'h5A; power-on mode cleared.
//  After writing MB0=8'h11 and MB1=8'h22: ctx=0 -> aext=8'h11; WRITE_CTX with 1 -> aext=8'h22.
//   With nir_idx=0, ir=1 -> aext=8'h22.
//  waddr=WAR: nwar low only in phases 2-3. rsthold during phase 3 of a WRITE_MBN -> MB unchanged,
//   power-on defaults return.

Source files
------------

// File: rtl/memory_bank_unit.sv
// Memory bank unit: eight 8-bit bank registers extending the address to 24 bits, plus the
// 4-phase cycle sequencer. Define MBU_IDX_EN to enable IR-indexed aext selection via i_nir_idx.
module memory_bank_unit #(
  parameter logic [7:0] ROM_BANK = 8'h80,
  parameter logic [7:0] RAM_BANK = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rsthold,
  input  logic [4:0] i_waddr,
  input  logic [4:0] i_raddr,
  input  logic [2:0] i_ir,
  input  logic       i_nir_idx,
  input  logic [7:0] i_ibus_in,
  output logic [7:0] o_ibus_out,
  output logic       o_ibus_oe,
  input  logic       i_nfpram_rom,
  output logic [7:0] o_aext,
  output logic       o_nwar,
  output logic [1:0] o_phase,
  output logic       o_t34
);

  localparam logic [4:0] ReadMbn  = 5'b11011;
  localparam logic [4:0] WriteMbn = 5'b11011;
  localparam logic [4:0] WriteCtx = 5'b11100;
  localparam logic [4:0] War      = 5'b00010;

  logic [1:0] r_phase;
  logic       r_ctx;
  logic       r_pon;
  logic [7:0] r_mb [8];

  logic       w_commit;
  logic [7:0] w_pon_val;
  logic [2:0] w_aext_idx;

  assign w_commit  = (r_phase == 2'd3);
  assign w_pon_val = i_nfpram_rom ? ROM_BANK : RAM_BANK;

  always_ff @(posedge i_clk) begin
    if (i_rsthold) begin
      r_phase <= 2'd0;
      r_ctx   <= 1'b0;
      r_pon   <= 1'b1;
    end else begin
      r_phase <= r_phase + 2'd1;
      if (w_commit && i_waddr == WriteCtx) r_ctx <= i_ibus_in[0];
      if (w_commit && i_waddr == WriteMbn) r_pon <= 1'b0;
    end
  end

  // Bank storage behaves like SRAM: never reset, but a reset edge still blocks a pending commit.
  always_ff @(posedge i_clk) begin
    if (!i_rsthold && w_commit && i_waddr == WriteMbn) r_mb[i_ir] <= i_ibus_in;
  end

`ifdef MBU_IDX_EN
  assign w_aext_idx = i_nir_idx ? {2'b00, r_ctx} : i_ir;
`else
  logic w_unused;
  assign w_unused   = i_nir_idx;
  assign w_aext_idx = {2'b00, r_ctx};
`endif

  always_comb begin
    o_ibus_oe  = (i_raddr == ReadMbn);
    o_ibus_out = r_pon ? w_pon_val : r_mb[i_ir];
    o_aext     = r_pon ? w_pon_val : r_mb[w_aext_idx];
    o_nwar     = !((i_waddr == War) && r_phase[1]);
    o_phase    = r_phase;
    o_t34      = r_phase[1];
  end

endmodule

// File: tb/tb_memory_bank_unit.sv
// Self-checking bench for memory_bank_unit; read/aext expectations flow through a scoreboard queue.
module tb_memory_bank_unit;

  localparam logic [4:0] ReadMbn  = 5'b11011;
  localparam logic [4:0] WriteMbn = 5'b11011;
  localparam logic [4:0] WriteCtx = 5'b11100;
  localparam logic [4:0] War      = 5'b00010;

  logic       clk = 1'b0;
  logic       rsthold;
  logic [4:0] waddr, raddr;
  logic [2:0] ir;
  logic       nir_idx, nfpram_rom;
  logic [7:0] ibus_in, ibus_out, aext;
  logic       ibus_oe, nwar, t34;
  logic [1:0] phase;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  sb_q[$];
  logic [1:0]  m_phase = 2'd0;

  always #5 clk = ~clk;

  memory_bank_unit dut (
    .i_clk       (clk),
    .i_rsthold   (rsthold),
    .i_waddr     (waddr),
    .i_raddr     (raddr),
    .i_ir        (ir),
    .i_nir_idx   (nir_idx),
    .i_ibus_in   (ibus_in),
    .o_ibus_out  (ibus_out),
    .o_ibus_oe   (ibus_oe),
    .i_nfpram_rom(nfpram_rom),
    .o_aext      (aext),
    .o_nwar      (nwar),
    .o_phase     (phase),
    .o_t34       (t34)
  );

  // Reference phase counter.
  always @(posedge clk) m_phase <= rsthold ? 2'd0 : m_phase + 2'd1;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      exp = sb_q.pop_front();
      check_eq(tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    @(negedge clk);
    raddr = ReadMbn;
    ir    = idx;
    sb_q.push_back(exp);
    #1;
    sb_check(tag, ibus_out);
    check_eq({tag, "_oe"}, {7'd0, ibus_oe}, 8'd1);
  endtask

  task automatic ax(input string tag, input logic [7:0] exp);
    @(negedge clk);
    sb_q.push_back(exp);
    #1;
    sb_check(tag, aext);
  endtask

  // Hold the write code until the phase-3 edge; optionally assert reset on that same edge.
  task automatic wr(input logic [4:0] code, input logic [2:0] idx, input logic [7:0] data,
                    input bit rst_at_commit);
    int n;
    @(negedge clk);
    waddr   = code;
    ir      = idx;
    ibus_in = data;
    n = 0;
    while (m_phase != 2'd3 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) check_eq("wr_phase_timeout", {6'd0, m_phase}, 8'd3);
    if (rst_at_commit) rsthold = 1'b1;
    @(negedge clk);
    waddr = 5'd0;
  endtask

  initial begin
    rsthold = 1'b1; waddr = '0; raddr = '0; ir = '0;
    nir_idx = 1'b1; nfpram_rom = 1'b0; ibus_in = '0;
    repeat (5) @(negedge clk);
    #1;
    check_eq("rst_phase", {6'd0, phase}, 8'd0);
    check_eq("rst_t34", {7'd0, t34}, 8'd0);
    check_eq("rst_nwar", {7'd0, nwar}, 8'd1);
    check_eq("rst_oe", {7'd0, ibus_oe}, 8'd0);
    rsthold = 1'b0;
    begin
      logic [1:0] seq_p [5];
      logic       seq_t [5];
      seq_p = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      seq_t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        check_eq($sformatf("phase%0d", i), {6'd0, phase}, {6'd0, seq_p[i]});
        check_eq($sformatf("t34_%0d", i), {7'd0, t34}, {7'd0, seq_t[i]});
      end
    end

    // Power-on defaults, live from nfpram_rom.
    nfpram_rom = 1'b0;
    for (int i = 0; i < 8; i++) rd($sformatf("pon_ram_ir%0d", i), 3'(i), 8'h00);
    ax("pon_ram_aext", 8'h00);
    nfpram_rom = 1'b1;
    for (int i = 0; i < 8; i++) rd($sformatf("pon_rom_ir%0d", i), 3'(i), 8'h80);
    ax("pon_rom_aext", 8'h80);
    raddr = 5'd1;
    #1 check_eq("unknown_raddr_oe", {7'd0, ibus_oe}, 8'd0);

    // WAR strobe follows t34.
    @(negedge clk);
    waddr = War;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq($sformatf("nwar_%0d", i), {7'd0, nwar}, {7'd0, ~m_phase[1]});
      @(negedge clk);
    end
    waddr = 5'd0;
    #1 check_eq("nwar_idle", {7'd0, nwar}, 8'd1);

    // First write clears power-on mode.
    wr(WriteMbn, 3'd3, 8'h5A, 1'b0);
    rd("mb3_5a", 3'd3, 8'h5A);
    wr(WriteMbn, 3'd0, 8'h11, 1'b0);
    wr(WriteMbn, 3'd1, 8'h22, 1'b0);
    nfpram_rom = 1'b0;
    rd("mb0_11", 3'd0, 8'h11);
    rd("mb1_22", 3'd1, 8'h22);
    raddr = 5'd0;
    ax("aext_ctx0", 8'h11);
    wr(WriteCtx, 3'd5, 8'h01, 1'b0);
    ax("aext_ctx1", 8'h22);
    nir_idx = 1'b0;
    ir = 3'd1;
    ax("aext_idx_ir1", 8'h22);
    ir = 3'd0;
`ifdef MBU_IDX_EN
    ax("aext_idx_ir0", 8'h11);
`else
    ax("aext_idx_ir0", 8'h22);
`endif
    nir_idx = 1'b1;

    // Read during write of the same register: old value until the commit edge.
    wr(WriteMbn, 3'd2, 8'h44, 1'b0);
    @(negedge clk);
    raddr = ReadMbn; waddr = WriteMbn; ir = 3'd2; ibus_in = 8'h33;
    while (m_phase != 2'd3) begin
      sb_q.push_back(8'h44);
      #1 sb_check("rw_old", ibus_out);
      @(negedge clk);
    end
    sb_q.push_back(8'h44);
    #1 sb_check("rw_old_p3", ibus_out);
    @(negedge clk);
    waddr = 5'd0;
    sb_q.push_back(8'h33);
    #1 sb_check("rw_new", ibus_out);

    // Reset on the commit edge: write dropped, power-on defaults return.
    nfpram_rom = 1'b1;
    wr(WriteMbn, 3'd3, 8'h77, 1'b1);
    #1 check_eq("rstmid_phase", {6'd0, phase}, 8'd0);
    rd("rstmid_pon", 3'd3, 8'h80);
    ax("rstmid_aext", 8'h80);
    @(negedge clk);
    rsthold = 1'b0;
    wr(WriteMbn, 3'd0, 8'h11, 1'b0);
    rd("rstmid_mb3_kept", 3'd3, 8'h5A);
    ax("rstmid_ctx_reset", 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
